instr_prefetch_queue: RTL

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_prefetch_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: instruction/PC widths, PC increment,
// the queue payload carried from the memory response to IF/ID, and the
// prefetch-queue control state.
package pipeline_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // RUN: responses are enqueued. DRAIN: stale responses are still in flight.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } pf_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Storage for the instruction prefetch queue.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears storage)
//   flush           empties the queue; overrides push/pop in the same cycle
//   push, wdata     enqueue one entry
//   pop             dequeue the head entry
//   head            registered head entry (storage word at the read pointer)
//   count           current occupancy, 0..DEPTH
module fetch_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           wdata,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CNT_W'(DEPTH));
  // A push into a full queue is only accepted alongside a pop.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && (count != '0);
  assign head  = mem[rd_ptr];

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PTR_W'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to instruction
// memory, buffers in-order responses, and presents them to the IF/ID register.
// A redirect flushes the queue, restarts fetch at redirect_pc and marks all
// in-flight responses for discard.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   mem_req, mem_addr         fetch request and word-aligned byte address
//   mem_gnt                   request accepted this cycle
//   mem_rvalid, mem_rdata     in-order read response
//   redirect, redirect_pc     taken branch and new fetch address
//   out_valid, out_ready      head handshake with IF/ID
//   out_instr, out_pc         head instruction and its address
module instr_prefetch_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [INSTR_W-1:0] mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INSTR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W = 2;
  localparam int unsigned SUM_W = 8;

  pf_state_t          state;
  pf_state_t          state_n;
  logic [OUT_W-1:0]   outstanding;
  logic [OUT_W-1:0]   outstanding_n;
  logic [OUT_W-1:0]   discard;
  logic [OUT_W-1:0]   discard_n;
  logic [OUT_W-1:0]   out_after;
  logic [OUT_W-1:0]   live;
  logic [INSTR_W-1:0] fetch_pc;
  logic [INSTR_W-1:0] fetch_pc_n;
  logic [INSTR_W-1:0] resp_pc;
  logic [INSTR_W-1:0] resp_pc_n;
  logic               run_en;
  logic [CNT_W-1:0]   occ;
  fetch_entry_t       head;
  fetch_entry_t       wentry;
  logic               rv_eff;
  logic               room;
  logic               grant;
  logic               drop;
  logic               push;
  logic               pop;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv_eff = mem_rvalid && (outstanding != '0);
  // Requests whose responses will actually be enqueued.
  assign live   = outstanding - discard;
  assign room   = (SUM_W'(occ) + SUM_W'(live)) < SUM_W'(DEPTH);

  // Combinational so a redirect cancels the request in its own cycle;
  // run_en holds requests off until the first edge after reset release.
  assign mem_req = run_en && !redirect && room &&
                   (SUM_W'(outstanding) < SUM_W'(MAX_OUT));
  assign grant   = mem_req && mem_gnt;

  assign drop      = (state == ST_DRAIN);
  assign push      = rv_eff && !drop && !redirect;
  assign out_valid = (occ != '0);
  assign pop       = out_valid && out_ready && !redirect;

  // Responses return in order, so resp_pc tracks the address of the next live one.
  assign wentry    = '{pc: resp_pc, instr: mem_rdata};
  assign mem_addr  = fetch_pc;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .head  (head),
    .count (occ)
  );

  // Control and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_RUN;
      outstanding <= '0;
      discard     <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      run_en      <= 1'b0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      run_en      <= 1'b1;
    end
  end

  // Next-state: fetch/response address tracking and discard bookkeeping.
  always_comb begin
    state_n       = state;
    discard_n     = discard;
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    out_after     = outstanding - OUT_W'(rv_eff);
    outstanding_n = out_after + OUT_W'(grant);

    if (redirect) begin
      fetch_pc_n = redirect_pc;
      resp_pc_n  = redirect_pc;
    end else begin
      if (grant) fetch_pc_n = fetch_pc + INSTR_W'(PC_INC);
      if (push)  resp_pc_n  = resp_pc + INSTR_W'(PC_INC);
    end

    // On redirect every request still in flight is stale; this already
    // includes earlier pending discards and is bounded by MAX_OUT.
    case (state)
      ST_RUN: begin
        if (redirect) begin
          discard_n = out_after;
          if (out_after != '0) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (redirect) begin
          discard_n = out_after;
          if (out_after == '0) state_n = ST_RUN;
        end else if (rv_eff) begin
          discard_n = discard - OUT_W'(1);
          if (discard == OUT_W'(1)) state_n = ST_RUN;
        end
      end
      default: begin
        state_n   = ST_RUN;
        discard_n = '0;
      end
    endcase
  end

endmodule
